// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I instruction fields, opcodes and register-usage decode
package rv32i_pkg;

  typedef logic [31:0] rv32_inst_t;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_IMM    = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } rv32i_opcode_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv32_fields_t;

  typedef struct packed {
    logic rs1_used;
    logic rs2_used;
    logic rd_used;
    logic is_system;
    logic illegal;
  } rv32i_reg_use_t;

  function automatic rv32_fields_t rv32_get_fields(input rv32_inst_t inst);
    return rv32_fields_t'(inst);
  endfunction

  function automatic rv32i_reg_use_t rv32i_get_reg_use(input rv32_fields_t f);
    rv32i_reg_use_t u;
    u = '0;
    case (rv32i_opcode_t'(f.opcode))
      OPC_OP: begin
        u.rs1_used = 1'b1;
        u.rs2_used = 1'b1;
        u.rd_used  = 1'b1;
      end
      OPC_IMM, OPC_LOAD, OPC_JALR: begin
        u.rs1_used = 1'b1;
        u.rd_used  = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        u.rs1_used = 1'b1;
        u.rs2_used = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: u.rd_used = 1'b1;
      OPC_SYSTEM: begin
        // funct3 001..011 are register CSR ops, 101..111 immediate CSR ops, 000 is ECALL/EBREAK
        u.is_system = 1'b1;
        if (!f.funct3[2] && f.funct3[1:0] != 2'b00) begin
          u.rs1_used = 1'b1;
          u.rd_used  = 1'b1;
        end else if (f.funct3[2] && f.funct3[1:0] != 2'b00) begin
          u.rd_used  = 1'b1;
        end
      end
      default: u.illegal = 1'b1;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/rv32i_scoreboard_counters.sv
// rtl/rv32i_scoreboard_counters.sv - 31 pending-write counters with read ports and sticky error
// RV32I_SCOREBOARD_BYPASS_EN: drain_zero_o also treats counters retired this cycle as zero.
module rv32i_scoreboard_counters #(
  parameter int PENDING_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc_en_i,
  input  logic [4:0]               inc_rd_i,
  input  logic                     dec_en_i,
  input  logic [4:0]               dec_rd_i,
  input  logic [4:0]               rs1_idx_i,
  input  logic [4:0]               rs2_idx_i,
  input  logic [4:0]               rd_idx_i,
  output logic [PENDING_WIDTH-1:0] rs1_cnt_o,
  output logic [PENDING_WIDTH-1:0] rs2_cnt_o,
  output logic [PENDING_WIDTH-1:0] rd_cnt_o,
  output logic                     all_zero_o,
  output logic                     drain_zero_o,
  output logic                     error_o
);

  logic [PENDING_WIDTH-1:0] cnt_q [1:31];
  logic [PENDING_WIDTH-1:0] cnt_d [1:31];
  logic                     error_q, error_d;

  always_comb begin
    error_d      = error_q;
    all_zero_o   = 1'b1;
    drain_zero_o = 1'b1;
    for (int i = 1; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_en_i && inc_rd_i == 5'(i)) cnt_d[i] = cnt_d[i] + PENDING_WIDTH'(1);
      // A retire against an idle counter is flagged and never underflows
      if (dec_en_i && dec_rd_i == 5'(i)) begin
        if (cnt_q[i] == '0) error_d = 1'b1;
        else                cnt_d[i] = cnt_d[i] - PENDING_WIDTH'(1);
      end
      if (cnt_q[i] != '0) all_zero_o = 1'b0;
`ifdef RV32I_SCOREBOARD_BYPASS_EN
      if (cnt_q[i] != '0 && !(cnt_q[i] == PENDING_WIDTH'(1) && dec_en_i && dec_rd_i == 5'(i)))
        drain_zero_o = 1'b0;
`endif
    end
`ifndef RV32I_SCOREBOARD_BYPASS_EN
    drain_zero_o = all_zero_o;
`endif
  end

  always_comb begin
    rs1_cnt_o = '0;
    rs2_cnt_o = '0;
    rd_cnt_o  = '0;
    for (int i = 1; i < 32; i++) begin
      if (rs1_idx_i == 5'(i)) rs1_cnt_o = cnt_q[i];
      if (rs2_idx_i == 5'(i)) rs2_cnt_o = cnt_q[i];
      if (rd_idx_i  == 5'(i)) rd_cnt_o  = cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      error_q <= 1'b0;
      for (int i = 1; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      error_q <= error_d;
      for (int i = 1; i < 32; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign error_o = error_q;

endmodule

// File: rtl/rv32i_issue_scoreboard.sv
// rtl/rv32i_issue_scoreboard.sv - in-order RV32I issue with RAW/WAW scoreboard and SYSTEM drain
// RV32I_SCOREBOARD_BYPASS_EN: sources retired by the same-cycle write-back count as ready.
import rv32i_pkg::*;

module rv32i_issue_scoreboard #(
  parameter int PENDING_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [31:0] dec_inst,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [31:0] issue_inst,
  output logic        issue_illegal,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        error
);

  typedef enum logic {ST_ISSUE, ST_DRAIN} state_e;

  localparam logic [PENDING_WIDTH-1:0] CNT_MAX = {PENDING_WIDTH{1'b1}};

  state_e                   state_q;
  logic                     valid_q, valid_d;
  logic [31:0]              inst_q, inst_d;
  logic                     illegal_q, illegal_d;
  rv32_fields_t             fields;
  rv32i_reg_use_t           use_w;
  logic [PENDING_WIDTH-1:0] rs1_cnt, rs2_cnt, rd_cnt;
  logic                     all_zero, drain_zero;
  logic                     rs1_act, rs2_act, rd_act;
  logic                     rs1_busy, rs2_busy;
  logic                     hazard, buf_free, sys_ok, accept;

  assign fields  = rv32_get_fields(dec_inst);
  assign use_w   = rv32i_get_reg_use(fields);
  assign rs1_act = use_w.rs1_used && fields.rs1 != 5'd0;
  assign rs2_act = use_w.rs2_used && fields.rs2 != 5'd0;
  assign rd_act  = use_w.rd_used  && fields.rd  != 5'd0;

`ifdef RV32I_SCOREBOARD_BYPASS_EN
  assign rs1_busy = rs1_cnt != '0 &&
                    !(rs1_cnt == PENDING_WIDTH'(1) && wb_valid && wb_rd == fields.rs1);
  assign rs2_busy = rs2_cnt != '0 &&
                    !(rs2_cnt == PENDING_WIDTH'(1) && wb_valid && wb_rd == fields.rs2);
`else
  assign rs1_busy = rs1_cnt != '0;
  assign rs2_busy = rs2_cnt != '0;
`endif

  assign hazard    = (rs1_act && rs1_busy) || (rs2_act && rs2_busy) || (rd_act && rd_cnt == CNT_MAX);
  assign buf_free  = !valid_q || issue_ready;
  assign sys_ok    = !use_w.is_system || all_zero;
  assign dec_ready = rst && state_q == ST_ISSUE && !hazard && buf_free && sys_ok;
  assign accept    = dec_valid && dec_ready;

  rv32i_scoreboard_counters #(.PENDING_WIDTH(PENDING_WIDTH)) u_counters (
    .clk          (clk),
    .rst          (rst),
    .inc_en_i     (accept && rd_act),
    .inc_rd_i     (fields.rd),
    .dec_en_i     (wb_valid && wb_rd != 5'd0),
    .dec_rd_i     (wb_rd),
    .rs1_idx_i    (fields.rs1),
    .rs2_idx_i    (fields.rs2),
    .rd_idx_i     (fields.rd),
    .rs1_cnt_o    (rs1_cnt),
    .rs2_cnt_o    (rs2_cnt),
    .rd_cnt_o     (rd_cnt),
    .all_zero_o   (all_zero),
    .drain_zero_o (drain_zero),
    .error_o      (error)
  );

  // The buffer refills in the same cycle it drains, giving one issue per cycle
  always_comb begin
    valid_d   = valid_q;
    inst_d    = inst_q;
    illegal_d = illegal_q;
    if (accept) begin
      valid_d   = 1'b1;
      inst_d    = dec_inst;
      illegal_d = use_w.illegal;
    end else if (issue_ready) begin
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_ISSUE;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      illegal_q <= illegal_d;
      case (state_q)
        ST_ISSUE: if (dec_valid && use_w.is_system && !(all_zero && buf_free)) state_q <= ST_DRAIN;
        ST_DRAIN: if (drain_zero && !valid_q) state_q <= ST_ISSUE;
        default:  state_q <= ST_ISSUE;
      endcase
    end
  end

  assign issue_valid   = valid_q;
  assign issue_inst    = inst_q;
  assign issue_illegal = illegal_q;

endmodule

// File: tb/tb_rv32i_issue_scoreboard.sv
// tb/tb_rv32i_issue_scoreboard.sv - directed vectors with queue scoreboard for the issue controller
module tb_rv32i_issue_scoreboard;

`ifdef RV32I_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] ADDI1 = 32'h00100093;  // addi x1,x0,1
  localparam logic [31:0] ADDI2 = 32'h00200113;  // addi x2,x0,2
  localparam logic [31:0] ADD3  = 32'h002081B3;  // add  x3,x1,x2
  localparam logic [31:0] LUI5  = 32'h000012B7;  // lui  x5,1
  localparam logic [31:0] LW6   = 32'h00002303;  // lw   x6,0(x0)
  localparam logic [31:0] LW8   = 32'h00002403;  // lw   x8,0(x0)
  localparam logic [31:0] CSR   = 32'h300110F3;  // csrrw x1,mstatus,x2
  localparam logic [31:0] ADDI4 = 32'h00400213;  // addi x4,x0,4
  localparam logic [31:0] RD4   = 32'h00020493;  // addi x9,x4,0
  localparam logic [31:0] X0ADD = 32'h00000033;  // add  x0,x0,x0
  localparam logic [31:0] ILL   = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_inst;
  logic        issue_valid, issue_ready, issue_illegal;
  logic [31:0] issue_inst;
  logic        wb_valid, error;
  logic [4:0]  wb_rd;

  typedef struct {
    logic [31:0] inst;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rv32i_issue_scoreboard #(.PENDING_WIDTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_inst      (dec_inst),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_inst    (issue_inst),
    .issue_illegal (issue_illegal),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .error         (error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // One cycle: drive at posedge+1, check dec_ready at posedge+4, return at next posedge+1
  task automatic cyc(input logic v, input logic [31:0] inst, input logic wv,
                     input logic [4:0] wr, input logic exp_rdy, input string name);
    dec_valid = v;
    dec_inst  = inst;
    wb_valid  = wv;
    wb_rd     = wr;
    #3;
    check(name, {31'd0, dec_ready}, {31'd0, exp_rdy});
    if (v && exp_rdy) exp_q.push_back('{inst, inst == ILL});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (issue_valid === 1'b1 && issue_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_issue: got %h, expected no instruction", issue_inst);
      end else begin
        e = exp_q.pop_front();
        check("issue_inst", issue_inst, e.inst);
        check("issue_illegal", {31'd0, issue_illegal}, {31'd0, e.ill});
      end
    end
  end

  initial begin
    rst = 1'b0; dec_valid = 1'b0; dec_inst = '0; wb_valid = 1'b0; wb_rd = '0; issue_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    dec_valid = 1'b1; dec_inst = ADDI1;
    #3;
    check("rst_dec_ready", {31'd0, dec_ready}, 32'd0);
    check("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
    check("rst_issue_inst", issue_inst, 32'd0);
    check("rst_issue_illegal", {31'd0, issue_illegal}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    dec_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;

    cyc(1, ADDI1, 0, 0, 1, "ind_a");
    cyc(1, ADDI2, 1, 1, 1, "ind_b");
    cyc(0, 0,     1, 2, 1, "ind_wb");

    issue_ready = 1'b0;
    cyc(1, ADDI2, 0, 0, 1, "bp_acc");
    cyc(1, ADDI1, 0, 0, 0, "bp_full");
    issue_ready = 1'b1;
    cyc(1, ADDI1, 1, 2, 1, "bp_drain");
    cyc(0, 0,     1, 1, 1, "bp_wb");

    cyc(1, ADDI1, 0, 0, 1, "raw_src");
    for (int i = 0; i < 4; i++) cyc(1, ADD3, 0, 0, 0, "raw_stall");
    cyc(1, ADD3, 1, 1, BYP, "raw_wb");
    if (!BYP) cyc(1, ADD3, 0, 0, 1, "raw_acc");
    cyc(0, 0, 1, 3, 1, "raw_wb3");

    for (int i = 0; i < 3; i++) cyc(1, LUI5, 0, 0, 1, "sat_acc");
    for (int i = 0; i < 2; i++) cyc(1, LUI5, 0, 0, 0, "sat_stall");
    cyc(1, LUI5, 1, 5, 0, "sat_wb");
    cyc(1, LUI5, 0, 0, 1, "sat_resume");
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 5, 1, "sat_drain");

    cyc(1, LW6, 0, 0, 1, "csr_ld6");
    cyc(1, LW8, 0, 0, 1, "csr_ld8");
    cyc(1, CSR, 0, 0, 0, "csr_enter");
    cyc(1, CSR, 0, 0, 0, "csr_drain");
    cyc(1, CSR, 1, 6, 0, "csr_wb6");
    cyc(1, CSR, 1, 8, 0, "csr_wb8");
    if (!BYP) cyc(1, CSR, 0, 0, 0, "csr_exit");
    cyc(1, CSR, 0, 0, 1, "csr_acc");
    cyc(0, 0, 1, 1, 1, "csr_wb1");

    cyc(1, ADDI4, 0, 0, 1, "sim_a");
    cyc(1, ADDI4, 1, 4, 1, "sim_b");
    cyc(1, RD4,   0, 0, 0, "sim_stall");
    cyc(1, RD4,   1, 4, BYP, "sim_wb");
    if (!BYP) cyc(1, RD4, 0, 0, 1, "sim_acc");
    cyc(0, 0, 1, 9, 1, "sim_wb9");

    check("err_pre", {31'd0, error}, 32'd0);
    cyc(0, 0, 1, 7, 1, "spur_wb");
    check("err_set", {31'd0, error}, 32'd1);
    cyc(1, X0ADD, 0, 0, 1, "x0_a");
    cyc(1, X0ADD, 0, 0, 1, "x0_b");
    cyc(1, ILL,   0, 0, 1, "ill");
    cyc(0, 0,     0, 0, 1, "idle");
    check("err_sticky", {31'd0, error}, 32'd1);

    cyc(1, ADDI1, 0, 0, 1, "mid_acc");
    rst = 1'b0; dec_valid = 1'b0;
    #3;
    check("mid_rst_ready", {31'd0, dec_ready}, 32'd0);
    check("mid_rst_buf", {31'd0, issue_valid}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("post_rst_valid", {31'd0, issue_valid}, 32'd0);
    check("post_rst_inst", issue_inst, 32'd0);
    check("post_rst_error", {31'd0, error}, 32'd0);
    cyc(0, 0, 1, 1, 1, "post_rst_wb");
    check("post_rst_wb_err", {31'd0, error}, 32'd1);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv32i_issue_scoreboard.md
# rv32i_issue_scoreboard

In-order issue controller between RV32I decode and the execute units. It tracks outstanding register writes in a per-register scoreboard and stalls instructions with RAW or WAW hazards. SYSTEM instructions are serialized behind a full pipeline drain. Accepted instructions pass through a one-entry registered output buffer to the execute stage.

## Interface
- PENDING_WIDTH, 2: bits per scoreboard counter; maximum in-flight writes per register is 2^PENDING_WIDTH-1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- dec_valid  in  1  decode has an instruction.
- dec_ready  out  1  instruction accepted this cycle when dec_valid && dec_ready.
- dec_inst  in  32  raw rv32_inst_t.
- issue_valid  out  1  output buffer holds an instruction.
- issue_ready  in  1  execute consumes the buffer this cycle.
- issue_inst  out  32  buffered instruction.
- issue_illegal  out  1  buffered opcode is not a known rv32i_opcode_t.
- wb_valid  in  1  a write-back retires this cycle.
- wb_rd  in  5  destination of the retiring write-back.
- error  out  1  sticky; set on write-back to a register whose counter is 0.

## Operation
- Fields are decoded with rv32_get_fields. Usage by opcode:
  - OP: rs1, rs2, rd.
  - IMM, LOAD, JALR: rs1, rd.
  - STORE, BRANCH: rs1, rs2.
  - LUI, AUIPC, JAL: rd.
  - SYSTEM: CSRRW/S/C read rs1 and write rd; CSRR*I and ENV write rd only for CSRR*I.
  - Undefined opcode: no reads or writes; issue_illegal=1.
- Any rd/rs equal to x0 is ignored.
- Hazard is true when:
  - a used rs has a nonzero count, or
  - the written rd's count is at maximum (saturation stall).
- dec_ready = state==ISSUE && !hazard && (!issue_valid || issue_ready). For SYSTEM, all counters must also be 0 and the buffer empty or draining this cycle.
- On accept: the buffer loads dec_inst, and count[rd] increments.
- On wb_valid with wb_rd≠0: count[wb_rd] decrements. If the count is already 0, it stays 0 and error is set.
- Increment and decrement on the same register in the same cycle: the count is unchanged.
- FSM:
  - ISSUE: normal issue. A SYSTEM instruction presented while counters are nonzero or the buffer is occupied moves to DRAIN.
  - DRAIN: dec_ready=0. Returns to ISSUE the cycle after all counters are 0 and issue_valid=0. The SYSTEM instruction is accepted in ISSUE on the following cycle.
- Reset values:
  - issue_valid=0, issue_inst=0, issue_illegal=0, error=0.
  - All counters 0; state ISSUE.
  - dec_ready is 0 while rst is asserted.
- Reset mid-operation discards the buffered instruction and all pending counts. Write-backs arriving after reset for pre-reset instructions set error.

## Timing
- Accept in cycle N: issue_valid=1 from N+1, and count[rd] is incremented in N+1.
- Throughput is 1 instruction/cycle with no hazards and issue_ready held high (the buffer refills while it drains).
- A write-back in cycle N clears the counter in N+1. Without bypass, a dependent instruction is accepted in N+1 at the earliest.
- dec_ready depends combinationally on dec_inst, the counters, issue_ready and (with bypass) wb_valid/wb_rd. It does not depend on dec_valid.
- Drain cost for SYSTEM: one extra cycle after the pipeline empties.

## Configuration
- RV32I_SCOREBOARD_BYPASS_EN defined: a source whose count is 1 and which is retired by wb_valid/wb_rd in the same cycle is treated as ready. The dependent instruction is accepted in cycle N, not N+1. DRAIN also exits in the cycle the last write-back arrives.
- Undefined: strict register-only check as described above. This removes the wb→dec_ready combinational path.

## Structure
- In the rv32i package:
  - rv32i_reg_use_t struct (rs1_used, rs2_used, rd_used, is_system, illegal).
  - rv32i_get_reg_use(rv32_fields_t) function, shared with forwarding logic.
- In the module: the FSM typedef (ISSUE, DRAIN) and the counter array.
- One sub-module: rv32i_scoreboard_counters.
  - Holds 31 saturating up/down counters with read ports for rs1, rs2 and rd.
  - Provides an all-zero flag and error detection.

## Test plan
- Independent stream (addi x1,x0,1; addi x2,x0,2), issue_ready=1, immediate write-backs → one accept per cycle; issue_inst matches in N+1.
- RAW: add x3,x1,x2 after addi x1 with write-back delayed to cycle 5 → dec_ready=0 in cycles 1–5. Accept in cycle 6, or cycle 5 with bypass.
- Saturation at PENDING_WIDTH=2: four lui x5 with no write-back → three accepted, the fourth stalls until one wb_rd=5.
- csrrw x1,mstatus,x2 behind two pending loads → FSM enters DRAIN with dec_ready=0 until both write-backs and an empty buffer, then the CSR is accepted.
- Simultaneous accept of addi x4 and write-back wb_rd=4 with count 1 → count stays 1; an x4 reader then stalls.
- Spurious wb_rd=7 with count 0 → error=1 and stays set until rst=0; x0 instructions never stall.
